// File: rtl/ctrl_result_reorder_fifo.sv
// Result-path row buffer: lane-order mode (pass/reverse) applied at write time,
// DEPTH-entry first-word-fall-through FIFO with valid/ready on both sides.
module ctrl_result_reorder_fifo #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int NUM_LANES      = 8,
    parameter int DEPTH          = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  rev_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_LANES*PARTIAL_SUM_BW-1:0]   in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_LANES*PARTIAL_SUM_BW-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]            count
);

    localparam int W     = NUM_LANES * PARTIAL_SUM_BW;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     row_ordered;
    logic             push;
    logic             pop;

    assign in_ready  = !rst && (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Only whole lanes move; bit order inside each partial sum is untouched.
    always_comb begin
        row_ordered = in_data;
        if (rev_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                row_ordered[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
                    in_data[(NUM_LANES-1-i)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
            end
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= row_ordered;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count == CNT_FULL))
                else $error("push while full");
            assert (!(pop && count == '0))
                else $error("pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_result_reorder_fifo.sv
// Directed bench for ctrl_result_reorder_fifo: reorder modes, full/empty, wrap, flush, reset.
module tb_ctrl_result_reorder_fifo;

    localparam int BW = 20;
    localparam int NL = 8;
    localparam int W  = BW * NL;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         rev_en;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   count;

    int errors = 0;
    int checks = 0;

    ctrl_result_reorder_fifo #(.PARTIAL_SUM_BW(BW), .NUM_LANES(NL), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .rev_en(rev_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    // Row whose lane i holds base + step*i.
    function automatic logic [W-1:0] mk(input int base, input int step);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) r[i*BW +: BW] = BW'(base + step * i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [W-1:0] d, input logic rv);
        in_valid = 1'b1; in_data = d; rev_en = rv;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rev_en = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", W'(in_ready), W'(1));

        // 1: reverse one row
        out_ready = 1'b1;
        push_row(mk(1, 1), 1'b1);
        check("t1_count1", W'(count), W'(1));
        check("t1_valid", W'(out_valid), W'(1));
        check("t1_rev_data", out_data, mk(8, -1));
        tick();
        check("t1_count0", W'(count), W'(0));
        check("t1_empty_data", out_data, '0);

        // 2: pass mode, then mixed modes per row
        push_row(mk(1, 1), 1'b0);
        check("t2_pass_data", out_data, mk(1, 1));
        tick();
        out_ready = 1'b0;
        push_row(mk(100, 1), 1'b1);
        push_row(mk(200, 3), 1'b0);
        push_row(mk(300, 7), 1'b1);
        check("t2_count3", W'(count), W'(3));
        out_ready = 1'b1;
        check("t2_row0_rev", out_data, mk(107, -1));
        tick();
        check("t2_row1_pass", out_data, mk(200, 3));
        tick();
        check("t2_row2_rev", out_data, mk(349, -7));
        tick();
        check("t2_drained", W'(count), W'(0));

        // 3: fill, ignore extra, drain with in_ready lag
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_row(mk(1000 * (k + 1), 1), 1'b0);
        check("t3_full_count", W'(count), W'(4));
        check("t3_full_in_ready", W'(in_ready), W'(0));
        push_row(mk(9000, 1), 1'b0);
        check("t3_extra_ignored", W'(count), W'(4));
        check("t3_head", out_data, mk(1000, 1));
        out_ready = 1'b1;
        check("t3_no_pushthrough", W'(in_ready), W'(0));
        tick();
        check("t3_count_after_pop", W'(count), W'(3));
        check("t3_in_ready_rise", W'(in_ready), W'(1));
        for (int k = 1; k < 4; k++) begin
            check($sformatf("t3_drain%0d", k), out_data, mk(1000 * (k + 1), 1));
            tick();
        end
        check("t3_empty", W'(out_valid), W'(0));

        // 4: steady push+pop across pointer wrap
        out_ready = 1'b0;
        push_row(mk(5000, 1), 1'b0);
        push_row(mk(5016, 1), 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = mk(5000 + 16 * (k + 2), 1); rev_en = 1'b0;
            check($sformatf("t4_order%0d", k), out_data, mk(5000 + 16 * k, 1));
            tick();
            check($sformatf("t4_count%0d", k), W'(count), W'(2));
        end
        in_valid = 1'b0;
        check("t4_tail0", out_data, mk(5160, 1));
        tick();
        check("t4_tail1", out_data, mk(5176, 1));
        tick();
        check("t4_empty", W'(count), W'(0));

        // 5: flush overrides push and pop
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_row(mk(7000 + 10 * k, 1), 1'b0);
        check("t5_count3", W'(count), W'(3));
        flush = 1'b1; out_ready = 1'b1;
        push_row(mk(7777, 2), 1'b0);
        flush = 1'b0;
        check("t5_count0", W'(count), W'(0));
        check("t5_out_valid", W'(out_valid), W'(0));
        push_row(mk(8000, 5), 1'b0);
        check("t5_new_row", out_data, mk(8000, 5));
        tick();
        check("t5_drained", W'(count), W'(0));

        // 6: async reset mid-operation
        out_ready = 1'b0;
        push_row(mk(11, 1), 1'b0);
        push_row(mk(22, 1), 1'b0);
        check("t6_count2", W'(count), W'(2));
        #3 rst = 1'b1;
        #1;
        check("t6_async_out_valid", W'(out_valid), W'(0));
        check("t6_async_in_ready", W'(in_ready), W'(0));
        check("t6_async_count", W'(count), W'(0));
        rst = 1'b0;
        tick();
        check("t6_post_count", W'(count), W'(0));
        out_ready = 1'b1;
        push_row(mk(40, 3), 1'b1);
        check("t6_first_count", W'(count), W'(1));
        check("t6_first_data", out_data, mk(61, -3));
        tick();
        check("t6_final_empty", W'(out_valid), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
